// File: rtl/uart_tx_arbiter_if.sv
// Requester/FIFO bundle for the UART transmit arbiter.
// master: arbiter side; slave: requesters plus FIFO write port.
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] reqData;
  logic [3:0]  reqValid;
  logic [3:0]  reqLast;
  logic [3:0]  reqReady;
  logic [3:0]  grant;
  logic [7:0]  din;
  logic        writeEn;
  logic        full;
  logic [11:0] wrDataCount;
  logic        msgError;

  modport master (
    input  req, reqData, reqValid, reqLast,
    input  full, wrDataCount,
    output reqReady, grant, din, writeEn, msgError
  );

  modport slave (
    output req, reqData, reqValid, reqLast,
    output full, wrDataCount,
    input  reqReady, grant, din, writeEn, msgError
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin message arbiter feeding a UART byte FIFO.
// Whole messages are granted; one idle cycle separates them.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int HOLDOFF    = 110,
  parameter int FIFO_DEPTH = 4096,
  parameter int MAX_MSG    = 64
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.master  bus
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_HOLD,
    S_IDLE,
    S_XFER,
    S_GAP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [HW-1:0] r_hold;
  logic [1:0]    r_owner;
  logic [3:0]    r_grant;
  logic [7:0]    r_din;
  logic          r_wen;
  logic          r_err;
  logic [6:0]    r_cnt;

  logic [1:0]    w_pick;
  logic [1:0]    w_cand;
  logic          w_any;
  logic          w_space;
  logic          w_acc;
  logic          w_last;
  logic          w_over;
  logic          w_abort;
  logic          w_hold_done;
  logic [6:0]    w_inc;
  logic [3:0]    w_ready;

  assign w_hold_done = (r_hold == HW'(HOLDOFF - 1));

  // one slot is kept free in the FIFO
  assign w_space = !bus.full &&
    ({20'd0, bus.wrDataCount} < 32'(FIFO_DEPTH - 1));

  assign w_acc = (r_state == S_XFER) &&
    bus.reqValid[r_owner] && w_space;

  assign w_inc  = r_cnt + 7'd1;
  assign w_last = w_acc && bus.reqLast[r_owner];
  assign w_over = w_acc && !bus.reqLast[r_owner] &&
    (w_inc == 7'(MAX_MSG));
  assign w_abort = (r_state == S_XFER) &&
    !w_acc && !bus.req[r_owner];

  // search starts just after the previous owner
  always_comb begin
    w_pick = r_owner;
    w_cand = r_owner;
    w_any  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_cand = r_owner + 2'(i);
      if (!w_any && bus.req[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_HOLD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_HOLD: if (w_hold_done) w_next = S_IDLE;
      S_IDLE: if (w_any) w_next = S_XFER;
      S_XFER:
        if (w_last || w_over || w_abort)
          w_next = S_GAP;
      S_GAP:  w_next = S_IDLE;
      default: w_next = S_HOLD;
    endcase
  end

  always_comb begin
    w_ready = '0;
    if (w_acc) w_ready[r_owner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold  <= '0;
      r_owner <= 2'd3;
      r_grant <= '0;
      r_din   <= '0;
      r_wen   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_wen <= w_acc;
      r_err <= w_over || w_abort;
      if (r_state == S_HOLD && !w_hold_done)
        r_hold <= r_hold + HW'(1);
      if (w_acc) begin
        r_din <= bus.reqData[{r_owner, 3'b000} +: 8];
        r_cnt <= w_inc;
      end
      unique case (r_state)
        S_IDLE:
          if (w_any) begin
            r_grant <= 4'b0001 << w_pick;
            r_owner <= w_pick;
            r_cnt   <= '0;
          end
        S_XFER:
          if (w_next == S_GAP) r_grant <= '0;
        default: ;
      endcase
    end
  end

  assign bus.reqReady = w_ready;
  assign bus.grant    = r_grant;
  assign bus.din      = r_din;
  assign bus.writeEn  = r_wen;
  assign bus.msgError = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter.
// Requester queues hold {last, data}; monitor logs FIFO writes.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [8:0]  mq [4][$];
  int          npop [4];
  int          stall_at = -1;
  int          stall_full = 0;
  int          stall_wdc = 0;
  logic [11:0] wdc_nom = 12'd0;

  logic [7:0] wdat [$];
  int         wcyc [$];
  int         gorder [$];
  int         nmsg = 0;
  int         cyc = 0;
  logic [3:0] prev_g = '0;

  function automatic int gidx(input logic [3:0] g);
    int k = -1;
    for (int i = 0; i < 4; i++)
      if (g[i]) k = i;
    return k;
  endfunction

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    prev_g <= bus.grant;
    if (!rst && bus.writeEn) begin
      wdat.push_back(bus.din);
      wcyc.push_back(cyc);
    end
    if (!rst && bus.msgError) nmsg <= nmsg + 1;
    if (bus.grant != 4'd0 && prev_g == 4'd0)
      gorder.push_back(gidx(bus.grant));
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic bit busy(input logic [3:0] m);
    bit b = 0;
    for (int r = 0; r < 4; r++)
      if (m[r] && mq[r].size() > 0) b = 1;
    return b;
  endfunction

  task automatic drive();
    logic [3:0]  rq = '0;
    logic [3:0]  ls = '0;
    logic [31:0] dt = '0;
    for (int r = 0; r < 4; r++)
      if (mq[r].size() > 0) begin
        rq[r] = 1'b1;
        ls[r] = mq[r][0][8];
        dt[8*r +: 8] = mq[r][0][7:0];
      end
    bus.req      = rq;
    bus.reqValid = rq;
    bus.reqLast  = ls;
    bus.reqData  = dt;
  endtask

  task automatic run(input int maxc,
                     input logic [3:0] stopm,
                     input int popcap);
    int c = 0;
    int tot = 0;
    logic [3:0] acc;
    bit stl;
    while (c < maxc && busy(stopm) && tot < popcap) begin
      drive();
      stl = 0;
      bus.full = 1'b0;
      bus.wrDataCount = wdc_nom;
      if (tot == stall_at && stall_full > 0) begin
        bus.full = 1'b1;
        stall_full--;
        stl = 1;
      end else if (tot == stall_at + 1 && stall_wdc > 0) begin
        bus.wrDataCount = 12'hFFF;
        stall_wdc--;
        stl = 1;
      end
      #1 acc = bus.reqReady;
      if (stl) chk("stall_rdy", {28'd0, acc}, 0);
      @(posedge clk); #1;
      c++;
      if (stl) chk("stall_wen", {31'd0, bus.writeEn}, 0);
      for (int r = 0; r < 4; r++)
        if (acc[r]) begin
          void'(mq[r].pop_front());
          npop[r]++;
          tot++;
        end
    end
    chk("run_budget", {31'd0, c < maxc}, 1);
    drive();
    bus.full = 1'b0;
    bus.wrDataCount = wdc_nom;
  endtask

  task automatic hold_check(input string tag);
    int bad = 0;
    for (int i = 0; i < 110; i++) begin
      @(posedge clk); #1;
      if (bus.grant != 0 || bus.writeEn ||
          bus.reqReady != 0)
        bad++;
    end
    chk({tag, "_quiet"}, bad, 0);
    @(posedge clk); #1;
    chk({tag, "_grant"}, {28'd0, bus.grant}, 32'h1);
  endtask

  task automatic chk_writes(input string tag,
                            input int base,
                            input logic [7:0] exp[$]);
    chk({tag, "_n"}, wdat.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (base + i < wdat.size())
        chk({tag, "_d"}, {24'd0, wdat[base+i]},
            {24'd0, exp[i]});
  endtask

  initial begin
    int wb;
    int mb;
    int gb;
    logic [7:0] ex [$];

    for (int r = 0; r < 4; r++) npop[r] = 0;
    bus.req = 4'b0001;
    bus.reqValid = '0;
    bus.reqLast = '0;
    bus.reqData = '0;
    bus.full = 1'b0;
    bus.wrDataCount = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", {28'd0, bus.grant}, 0);
    chk("rst_wen", {31'd0, bus.writeEn}, 0);
    chk("rst_din", {24'd0, bus.din}, 0);
    chk("rst_err", {31'd0, bus.msgError}, 0);
    chk("rst_rdy", {28'd0, bus.reqReady}, 0);
    @(negedge clk);
    rst = 1'b0;
    hold_check("hold1");

    // three-byte message from requester 0
    wb = wdat.size();
    mb = nmsg;
    mq[0].push_back({1'b0, 8'h50});
    mq[0].push_back({1'b0, 8'h42});
    mq[0].push_back({1'b1, 8'h31});
    run(50, 4'b1111, 1000);
    chk("m3_wen", {31'd0, bus.writeEn}, 1);
    chk("m3_din", {24'd0, bus.din}, 32'h31);
    chk("m3_gap", {28'd0, bus.grant}, 0);
    @(posedge clk); #1;
    chk("m3_idle_g", {28'd0, bus.grant}, 0);
    chk("m3_idle_w", {31'd0, bus.writeEn}, 0);
    ex = '{8'h50, 8'h42, 8'h31};
    chk_writes("m3", wb, ex);
    if (wdat.size() - wb == 3)
      chk("m3_back2back", wcyc[wb+2] - wcyc[wb], 2);
    chk("m3_err", nmsg - mb, 0);

    // requester 1 stalled by full, then by low space
    wb = wdat.size();
    mb = nmsg;
    wdc_nom = 12'd4094;
    stall_at = 3;
    stall_full = 5;
    stall_wdc = 2;
    for (int i = 0; i < 6; i++)
      mq[1].push_back({i == 5, 8'h10 + 8'(i)});
    run(80, 4'b1111, 1000);
    stall_at = -1;
    repeat (2) @(posedge clk);
    #1;
    ex = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    chk_writes("stall", wb, ex);
    chk("stall_err", nmsg - mb, 0);
    wdc_nom = 12'd0;

    // overlong stream from requester 2, requester 3 waits
    wb = wdat.size();
    mb = nmsg;
    gb = gorder.size();
    for (int i = 0; i < 70; i++)
      mq[2].push_back({1'b0, 8'h80 + 8'(i)});
    mq[3].push_back({1'b1, 8'hEE});
    run(300, 4'b1000, 1000);
    mq[2].delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    ex.delete();
    for (int i = 0; i < 64; i++) ex.push_back(8'h80 + 8'(i));
    ex.push_back(8'hEE);
    chk_writes("long", wb, ex);
    chk("long_pops", npop[2], 64);
    chk("long_err", nmsg - mb, 1);
    chk("long_ng", gorder.size() - gb, 2);
    if (gorder.size() - gb == 2) begin
      chk("long_g0", gorder[gb], 2);
      chk("long_g1", gorder[gb+1], 3);
    end

    // reset in the middle of a message
    for (int i = 0; i < 5; i++)
      mq[0].push_back({i == 4, 8'h61 + 8'(i)});
    run(50, 4'b1111, 2);
    chk("mid_wen", {31'd0, bus.writeEn}, 1);
    chk("mid_din", {24'd0, bus.din}, 32'h62);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_wen", {31'd0, bus.writeEn}, 0);
    chk("mid_rst_grant", {28'd0, bus.grant}, 0);
    chk("mid_rst_din", {24'd0, bus.din}, 0);
    chk("mid_rst_rdy", {28'd0, bus.reqReady}, 0);
    for (int r = 0; r < 4; r++) mq[r].delete();
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    wb = wdat.size();
    mb = nmsg;
    gb = gorder.size();
    mq[0].push_back({1'b0, 8'h01});
    mq[0].push_back({1'b1, 8'h02});
    mq[0].push_back({1'b0, 8'h03});
    mq[0].push_back({1'b1, 8'h04});
    mq[1].push_back({1'b0, 8'h11});
    mq[1].push_back({1'b1, 8'h12});
    mq[2].push_back({1'b0, 8'h21});
    mq[2].push_back({1'b1, 8'h22});
    mq[3].push_back({1'b0, 8'h31});
    mq[3].push_back({1'b1, 8'h32});
    drive();
    rst = 1'b0;
    hold_check("hold2");

    // round-robin with all four requesting
    run(200, 4'b1111, 1000);
    repeat (2) @(posedge clk);
    #1;
    ex = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21,
           8'h22, 8'h31, 8'h32, 8'h03, 8'h04};
    chk_writes("rr", wb, ex);
    chk("rr_ng", gorder.size() - gb, 5);
    for (int i = 0; i < 5; i++)
      if (gb + i < gorder.size())
        chk("rr_order", gorder[gb+i], i % 4);
    chk("rr_err", nmsg - mb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of message requesters (fixed at 4 in this revision).
REQ-002 Parameter HOLDOFF, default 110, clk cycles after reset before the first grant.
REQ-003 Parameter FIFO_DEPTH, default 4096, depth of the downstream UART byte FIFO.
REQ-004 Parameter MAX_MSG, default 64, maximum bytes per message before forced release.
REQ-005 clk  input  1  system clock; all logic on posedge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req  input  4  per-requester message-pending flag.
REQ-008 reqData  input  32  byte from requester i on bits [8i+7:8i].
REQ-009 reqValid  input  4  reqData byte of requester i is valid.
REQ-010 reqLast  input  4  current byte of requester i is the final byte of its message.
REQ-011 reqReady  output  4  byte of requester i accepted this cycle (combinational).
REQ-012 grant  output  4  one-hot registered grant; all-zero when no owner.
REQ-013 din  output  8  registered byte to FIFO write port.
REQ-014 writeEn  output  1  registered FIFO write strobe.
REQ-015 full  input  1  FIFO full flag.
REQ-016 wrDataCount  input  12  FIFO write-side occupancy.
REQ-017 msgError  output  1  one-cycle pulse on aborted or overlong message.

Function
REQ-018 States HOLD, IDLE, XFER, GAP; reset state is HOLD.
REQ-019 HOLD: counter increments each cycle; at count == HOLDOFF-1 go to IDLE; no grant, no writes.
REQ-020 IDLE: if any req bit set, grant the first set bit searching upward from (lastOwner+1) mod 4 with wrap; register grant, lastOwner, clear byte counter, go to XFER next cycle; else stay IDLE.
REQ-021 XFER: reqReady[g] = reqValid[g] && !full && wrDataCount < FIFO_DEPTH-1; all other reqReady bits 0.
REQ-022 On reqReady[g]: next cycle writeEn=1, din=reqData byte g; byte counter +1; otherwise writeEn=0 next cycle, din holds.
REQ-023 Accepted byte with reqLast[g]=1: next state GAP, grant cleared next cycle.
REQ-024 req[g] deasserted in XFER with no byte accepted that cycle: abort; pulse msgError; go to GAP.
REQ-025 Byte counter reaching MAX_MSG accepted bytes without reqLast: pulse msgError; go to GAP; the last accepted byte is still written.
REQ-026 GAP: exactly one cycle, grant zero, then IDLE; guarantees one idle cycle between messages.
REQ-027 Round-robin: after releasing requester k, priority starts at k+1; a continuously requesting requester cannot win twice while another waits.
REQ-028 full or low-space stall in XFER holds grant and state indefinitely; no byte dropped or duplicated.
REQ-029 Byte counter is 7 bits; no wrap possible since release occurs at MAX_MSG.
REQ-030 Simultaneous reqLast acceptance and MAX_MSG limit: treat as normal completion, no msgError.

Reset
REQ-031 rst asserted at any time, including mid-message, forces within the same cycle: state HOLD, hold counter 0, grant 0, writeEn 0, din 0, msgError 0, byte counter 0, lastOwner 3 (requester 0 has first priority).
REQ-032 reqReady is 0 throughout reset and HOLD.

Verification
REQ-033 Reset release, req=4'b0001 constant -> no writeEn for 110 cycles; grant=4'b0001 in cycle 111.
REQ-034 Requester 0 sends 3 bytes 0x50,0x42,0x31 (last on 0x31), FIFO empty -> writeEn high 3 consecutive cycles with din 0x50,0x42,0x31, then one GAP cycle.
REQ-035 req=4'b1111 held, each message 2 bytes -> grant order 0,1,2,3,0.
REQ-036 full asserted for 5 cycles mid-message -> reqReady 0 and writeEn 0 during stall; remaining bytes written in order afterward, count unchanged.
REQ-037 Requester 2 streams 70 bytes with no reqLast -> exactly 64 writes, msgError pulse, grant moves to next requester.
REQ-038 rst pulsed after 2 of 5 bytes written -> writeEn 0 and grant 0 immediately; HOLD counting restarts from 0.
